// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder
//   Sequential RV32I instruction encoder. Packs opcode, funct and register
//   fields plus an immediate into a 32-bit instruction word held in a
//   one-entry output register. The LI pseudo-op (fmt 110) expands to ADDI,
//   LUI, or LUI followed by ADDI; the ADDI half is parked internally while
//   the LUI word waits for handoff.
//
//   Format codes: 000 R, 001 I, 010 S, 011 B, 100 U, 101 J, 110 LI,
//   111 reserved (accepted, dropped, o_err pulse).
//
//   Optional feature macro: ENCODER_CHECK_EN. When defined, immediates that
//   cannot be represented exactly (misaligned B/J targets, out-of-range
//   I/S/B/J values, U with nonzero low bits) cause the request to be dropped
//   with an o_err pulse. When undefined, extra bits are silently truncated.
//
//   Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both high. Request side: i_req_valid/o_req_ready. Instruction
//   side: o_inst_valid/i_inst_ready. Once o_inst_valid is high, o_inst and
//   o_inst_valid hold until i_inst_ready is seen.
//
//   Ports:
//     i_clk, i_rst               clock (rising edge), async active-high reset
//     i_req_valid, o_req_ready   request handshake
//     i_fmt, i_opcode, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm
//                                request fields
//     o_inst_valid, i_inst_ready, o_inst   instruction handshake and word
//     o_err                      one-cycle pulse when a request is dropped
//     o_inst_count               words handed off, wraps modulo 2^CNT_W
//     o_dbg_state                current FSM state (0 EMPTY, 1 FULL, 2 PEND2)
module rv32i_inst_encoder #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int          CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [2:0]       i_fmt,
   input  logic [6:0]       i_opcode,
   input  logic [2:0]       i_funct3,
   input  logic [6:0]       i_funct7,
   input  logic [4:0]       i_rd,
   input  logic [4:0]       i_rs1,
   input  logic [4:0]       i_rs2,
   input  logic [31:0]      i_imm,
   output logic             o_inst_valid,
   input  logic             i_inst_ready,
   output logic [31:0]      o_inst,
   output logic             o_err,
   output logic [CNT_W-1:0] o_inst_count,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_PEND2 = 2'd2
   } state_t;

   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_ADDI = 7'b0010011;

   state_t            state_q, state_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       pend_q, pend_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Encoder outputs for the request currently presented
   logic [31:0] enc_word0, enc_word1;
   logic        enc_two, enc_bad, enc_drop;
   logic [31:0] li_sum;
   logic        li_fits12;

   logic handoff, accept;

   assign li_sum    = i_imm + 32'h0000_0800;
   // Signed 12-bit fit: bits 31..11 all equal to the sign bit
   assign li_fits12 = (i_imm[31:11] == {21{i_imm[11]}});

   always_comb begin
      enc_word0 = NOP_INST;
      enc_word1 = NOP_INST;
      enc_two   = 1'b0;
      enc_bad   = 1'b0;
      case (i_fmt)
         3'b000: enc_word0 = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
         3'b001: enc_word0 = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
         3'b010: enc_word0 = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
         3'b011: enc_word0 = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
         3'b100: enc_word0 = {i_imm[31:12], i_rd, i_opcode};
         3'b101: enc_word0 = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                              i_rd, i_opcode};
         3'b110: begin
            if (li_fits12) begin
               enc_word0 = {i_imm[11:0], 5'd0, 3'b000, i_rd, OP_ADDI};
            end else if (i_imm[11:0] == 12'd0) begin
               enc_word0 = {i_imm[31:12], i_rd, OP_LUI};
            end else begin
               // +0x800 pre-compensates the sign extension of the ADDI half
               enc_word0 = {li_sum[31:12], i_rd, OP_LUI};
               enc_word1 = {i_imm[11:0], i_rd, 3'b000, i_rd, OP_ADDI};
               enc_two   = 1'b1;
            end
         end
         default: ;
      endcase
`ifdef ENCODER_CHECK_EN
      case (i_fmt)
         3'b001, 3'b010: enc_bad = !li_fits12;
         3'b011: enc_bad = i_imm[0] | (i_imm[31:12] != {20{i_imm[12]}});
         3'b100: enc_bad = (i_imm[11:0] != 12'd0);
         3'b101: enc_bad = i_imm[0] | (i_imm[31:20] != {12{i_imm[20]}});
         default: enc_bad = 1'b0;
      endcase
`else
      enc_bad = 1'b0;
`endif
   end

   assign enc_drop = (i_fmt == 3'b111) | enc_bad;

   assign o_inst_valid = (state_q != ST_EMPTY);
   assign o_req_ready  = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & i_inst_ready);
   assign handoff      = o_inst_valid & i_inst_ready;
   assign accept       = i_req_valid & o_req_ready;

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      pend_d  = pend_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, handoff};
      case (state_q)
         ST_EMPTY, ST_FULL: begin
            if ((state_q == ST_FULL) && handoff) begin
               state_d = ST_EMPTY;
               inst_d  = NOP_INST;
            end
            // In FULL, accept implies a handoff this same cycle
            if (accept) begin
               if (enc_drop) begin
                  err_d = 1'b1;
               end else if (enc_two) begin
                  state_d = ST_PEND2;
                  inst_d  = enc_word0;
                  pend_d  = enc_word1;
               end else begin
                  state_d = ST_FULL;
                  inst_d  = enc_word0;
               end
            end
         end
         ST_PEND2: begin
            if (handoff) begin
               state_d = ST_FULL;
               inst_d  = pend_q;
            end
         end
         default: begin
            state_d = ST_EMPTY;
            inst_d  = NOP_INST;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_EMPTY;
         inst_q  <= NOP_INST;
         pend_q  <= NOP_INST;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_inst       = inst_q;
   assign o_err        = err_q;
   assign o_inst_count = cnt_q;
   assign o_dbg_state  = state_q;

endmodule
